// File: rtl/vga_timing_gen_pkg.sv
// rtl/vga_timing_gen_pkg.sv - shared 640x480@60 timing constants for the VGA timing generator
package vga_timing_gen_pkg;

    localparam int unsigned CNT_W   = 10;
    localparam int unsigned FCNT_W  = 16;

    localparam int unsigned H_VISIBLE_DEF = 640;
    localparam int unsigned H_FRONT_DEF   = 16;
    localparam int unsigned H_SYNC_DEF    = 96;
    localparam int unsigned H_BACK_DEF    = 48;
    localparam int unsigned V_VISIBLE_DEF = 480;
    localparam int unsigned V_FRONT_DEF   = 10;
    localparam int unsigned V_SYNC_DEF    = 2;
    localparam int unsigned V_BACK_DEF    = 33;

    localparam int unsigned H_TOTAL = H_VISIBLE_DEF + H_FRONT_DEF + H_SYNC_DEF + H_BACK_DEF;
    localparam int unsigned V_TOTAL = V_VISIBLE_DEF + V_FRONT_DEF + V_SYNC_DEF + V_BACK_DEF;

endpackage

// File: rtl/vga_axis_counter.sv
// rtl/vga_axis_counter.sv - one timing axis: position counter with registered sync and look-ahead visible decode
module vga_axis_counter
    import vga_timing_gen_pkg::*;
#(
    parameter int unsigned VISIBLE = H_VISIBLE_DEF,
    parameter int unsigned FRONT   = H_FRONT_DEF,
    parameter int unsigned SYNC    = H_SYNC_DEF,
    parameter int unsigned BACK    = H_BACK_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             advance,
    output logic [CNT_W-1:0] pos,
    output logic             sync_n,
    output logic             wrap,
    output logic             visible_next
);

    localparam int unsigned      TOTAL    = VISIBLE + FRONT + SYNC + BACK;
    localparam logic [CNT_W-1:0] LAST     = CNT_W'(TOTAL - 1);
    localparam logic [CNT_W-1:0] VIS_END  = CNT_W'(VISIBLE);
    localparam logic [CNT_W-1:0] SYNC_BEG = CNT_W'(VISIBLE + FRONT);
    localparam logic [CNT_W-1:0] SYNC_END = CNT_W'(VISIBLE + FRONT + SYNC);

    logic [CNT_W-1:0] pos_next;

    // Decodes use the next position so registered outputs line up with pos.
    always_comb begin
        wrap     = advance && (pos == LAST);
        pos_next = pos;
        if (wrap) begin
            pos_next = '0;
        end else if (advance) begin
            pos_next = pos + CNT_W'(1);
        end
        visible_next = (pos_next < VIS_END);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pos    <= LAST;
            sync_n <= 1'b1;
        end else begin
            pos    <= pos_next;
            sync_n <= !((pos_next >= SYNC_BEG) && (pos_next < SYNC_END));
        end
    end

endmodule

// File: rtl/vga_timing_gen.sv
// rtl/vga_timing_gen.sv - VGA raster timing generator with coherent registered position, sync and frame outputs
module vga_timing_gen
    import vga_timing_gen_pkg::*;
#(
    parameter int unsigned H_VISIBLE = H_VISIBLE_DEF,
    parameter int unsigned H_FRONT   = H_FRONT_DEF,
    parameter int unsigned H_SYNC    = H_SYNC_DEF,
    parameter int unsigned H_BACK    = H_BACK_DEF,
    parameter int unsigned V_VISIBLE = V_VISIBLE_DEF,
    parameter int unsigned V_FRONT   = V_FRONT_DEF,
    parameter int unsigned V_SYNC    = V_SYNC_DEF,
    parameter int unsigned V_BACK    = V_BACK_DEF
) (
    input  logic              vga_clk,
    input  logic              reset,
    output logic [CNT_W-1:0]  DrawX,
    output logic [CNT_W-1:0]  DrawY,
    output logic              hs,
    output logic              vs,
    output logic              blank,
    output logic              frame_start,
    output logic              line_start,
    output logic [FCNT_W-1:0] frame_count
);

    logic              h_wrap;
    logic              v_wrap;
    logic              h_vis_next;
    logic              v_vis_next;
    logic [FCNT_W-1:0] frame_cnt_q;

    vga_axis_counter #(
        .VISIBLE (H_VISIBLE),
        .FRONT   (H_FRONT),
        .SYNC    (H_SYNC),
        .BACK    (H_BACK)
    ) u_h_axis (
        .clk          (vga_clk),
        .reset        (reset),
        .advance      (1'b1),
        .pos          (DrawX),
        .sync_n       (hs),
        .wrap         (h_wrap),
        .visible_next (h_vis_next)
    );

    // The vertical axis steps only on the cycle the line wraps.
    vga_axis_counter #(
        .VISIBLE (V_VISIBLE),
        .FRONT   (V_FRONT),
        .SYNC    (V_SYNC),
        .BACK    (V_BACK)
    ) u_v_axis (
        .clk          (vga_clk),
        .reset        (reset),
        .advance      (h_wrap),
        .pos          (DrawY),
        .sync_n       (vs),
        .wrap         (v_wrap),
        .visible_next (v_vis_next)
    );

    always_ff @(posedge vga_clk or posedge reset) begin
        if (reset) begin
            blank       <= 1'b0;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
            frame_cnt_q <= '0;
        end else begin
            blank       <= h_vis_next && v_vis_next;
            line_start  <= h_wrap;
            frame_start <= h_wrap && v_wrap;
            if (h_wrap && v_wrap) begin
                frame_cnt_q <= frame_cnt_q + FCNT_W'(1);
            end
        end
    end

    assign frame_count = frame_cnt_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb/tb_vga_timing_gen.sv - directed self-checking bench for vga_timing_gen on a reduced raster
module tb_vga_timing_gen;

    localparam int HV = 16, HF = 4, HS = 8, HB = 4;
    localparam int VV = 12, VF = 2, VS = 2, VB = 4;
    localparam int HT = HV + HF + HS + HB;
    localparam int VT = VV + VF + VS + VB;
    localparam int FT = HT * VT;

    logic        vga_clk = 1'b0;
    logic        reset   = 1'b1;
    logic [9:0]  DrawX;
    logic [9:0]  DrawY;
    logic        hs;
    logic        vs;
    logic        blank;
    logic        frame_start;
    logic        line_start;
    logic [15:0] frame_count;

    int          n_tests = 0;
    int          n_fail  = 0;
    int          cyc     = 0;
    int          ex;
    int          ey;
    logic [15:0] efc;

    vga_timing_gen #(
        .H_VISIBLE (HV), .H_FRONT (HF), .H_SYNC (HS), .H_BACK (HB),
        .V_VISIBLE (VV), .V_FRONT (VF), .V_SYNC (VS), .V_BACK (VB)
    ) dut (
        .vga_clk     (vga_clk),
        .reset       (reset),
        .DrawX       (DrawX),
        .DrawY       (DrawY),
        .hs          (hs),
        .vs          (vs),
        .blank       (blank),
        .frame_start (frame_start),
        .line_start  (line_start),
        .frame_count (frame_count)
    );

    always #5 vga_clk = ~vga_clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %0d expected %0d", tag, cyc, got, exp);
        end
    endtask

    // One clock; advance the reference raster and check every output.
    task automatic step();
        @(posedge vga_clk);
        @(negedge vga_clk);
        cyc++;
        ex = (ex == HT - 1) ? 0 : ex + 1;
        if (ex == 0) begin
            ey = (ey == VT - 1) ? 0 : ey + 1;
            if (ey == 0) efc = efc + 16'd1;
        end
        check("drawx", DrawX, ex);
        check("drawy", DrawY, ey);
        check("hs", hs, !((DrawX >= HV + HF) && (DrawX < HV + HF + HS)));
        check("vs", vs, !((DrawY >= VV + VF) && (DrawY < VV + VF + VS)));
        check("blank", blank, (DrawX < HV) && (DrawY < VV));
        check("frame_start", frame_start, (DrawX == 0) && (DrawY == 0));
        check("line_start", line_start, DrawX == 0);
        check("frame_count", frame_count, efc);
    endtask

    initial begin
        int fs1 = -1, fs2 = -1, last_ls = -1, gap_min = 1 << 30, gap_max = 0;
        int hs_low0 = 0, first_hs_x = -1, blank_low0 = 0, vs_low = 0, vs_first_y = -1;

        ex  = HT - 1;
        ey  = VT - 1;
        efc = 16'd0;

        repeat (3) @(negedge vga_clk);
        check("rst_drawx", DrawX, HT - 1);
        check("rst_drawy", DrawY, VT - 1);
        check("rst_hs", hs, 1);
        check("rst_vs", vs, 1);
        check("rst_blank", blank, 0);
        check("rst_frame_start", frame_start, 0);
        check("rst_line_start", line_start, 0);
        check("rst_frame_count", frame_count, 0);

        reset = 1'b0;
        step();
        check("c1_drawx", DrawX, 0);
        check("c1_drawy", DrawY, 0);
        check("c1_blank", blank, 1);
        check("c1_frame_start", frame_start, 1);
        check("c1_line_start", line_start, 1);
        check("c1_frame_count", frame_count, 1);

        while (cyc < 2 * FT + 1) begin
            if (frame_count == 16'd1 && DrawY == 0) begin
                if (!hs) begin
                    if (first_hs_x < 0) first_hs_x = int'(DrawX);
                    hs_low0++;
                end
                if (!blank) blank_low0++;
            end
            if (frame_count == 16'd1 && !vs) begin
                if (vs_first_y < 0) vs_first_y = int'(DrawY);
                vs_low++;
            end
            if (line_start) begin
                if (last_ls >= 0) begin
                    if (cyc - last_ls < gap_min) gap_min = cyc - last_ls;
                    if (cyc - last_ls > gap_max) gap_max = cyc - last_ls;
                end
                last_ls = cyc;
            end
            if (frame_start) begin
                if (fs1 < 0) fs1 = cyc;
                else if (fs2 < 0) fs2 = cyc;
            end
            step();
        end
        check("hs_low_width", hs_low0, HS);
        check("hs_first_x", first_hs_x, HV + HF);
        check("blank_low_line", blank_low0, HT - HV);
        check("vs_low_cycles", vs_low, VS * HT);
        check("vs_first_line", vs_first_y, VV + VF);
        check("line_period_min", gap_min, HT);
        check("line_period_max", gap_max, HT);
        check("frame_period", fs2 - fs1, FT);

        for (int i = 0; i < FT && !(DrawX == 10'(HV + HF + 4) && DrawY == 10'(VV + VF + 1)); i++) step();
        check("reach_mid_sync", (DrawX == 10'(HV + HF + 4)) && (DrawY == 10'(VV + VF + 1)), 1);
        check("pre_rst_hs", hs, 0);
        check("pre_rst_vs", vs, 0);
        #2 reset = 1'b1;
        #1;
        check("async_rst_hs", hs, 1);
        check("async_rst_vs", vs, 1);
        check("async_rst_blank", blank, 0);
        check("async_rst_drawx", DrawX, HT - 1);
        check("async_rst_drawy", DrawY, VT - 1);
        check("async_rst_frame_count", frame_count, 0);
        check("async_rst_line_start", line_start, 0);
        ex  = HT - 1;
        ey  = VT - 1;
        efc = 16'd0;
        repeat (2) @(negedge vga_clk);
        check("held_rst_drawx", DrawX, HT - 1);
        check("held_rst_hs", hs, 1);
        check("held_rst_vs", vs, 1);
        reset = 1'b0;
        step();
        check("rerun_drawx", DrawX, 0);
        check("rerun_frame_start", frame_start, 1);
        check("rerun_frame_count", frame_count, 1);
        repeat (2 * HT) step();

        force dut.frame_cnt_q = 16'hFFFF;
        #1;
        release dut.frame_cnt_q;
        efc = 16'hFFFF;
        check("forced_frame_count", frame_count, 16'hFFFF);
        for (int i = 0; i < FT + 2 && !frame_start; i++) step();
        check("wrap_frame_start_seen", frame_start, 1);
        check("wrap_frame_count", frame_count, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
